// File: rtl/prefix_pkg.sv
// Shared types and constants for the pipelined parallel-prefix subtractor.
// pg_t carries one propagate/generate pair through the prefix network.
package prefix_pkg;
  localparam int WIDTH    = 32;
  localparam int LATENCY  = 7;
  localparam int NUM_ROWS = 5;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Right-hand operand that turns a black cell into a plain register.
  localparam pg_t PG_IDENT = '{p: 1'b1, g: 1'b0};

  function automatic pg_t pg_combine(input pg_t l, input pg_t r);
    pg_t res;
    res.p = l.p & r.p;
    res.g = l.g | (l.p & r.g);
    return res;
  endfunction
endpackage

// File: rtl/pg_black_en.sv
// Registered black cell of the prefix network, loading only when en_i is high.
import prefix_pkg::*;

module pg_black_en (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  pg_t  l_i,
  input  pg_t  r_i,
  output pg_t  o_o
);
  pg_t o_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q <= '0;
    end else if (en_i) begin
      o_q <= pg_combine(l_i, r_i);
    end
  end

  assign o_o = o_q;
endmodule

// File: rtl/prefix_sub_pipe.sv
// 32-bit subtractor a - b - bin built as a 7-stage pipelined Kogge-Stone prefix
// adder (a + ~b + ~bin) with a single global stall driven by the output handshake.
import prefix_pkg::*;

module prefix_sub_pipe (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  logic             adv_s;
  logic [NUM_ROWS:0] v_q;
  logic [WIDTH-1:0] a_q  [0:NUM_ROWS];
  logic [WIDTH-1:0] nb_q [0:NUM_ROWS];
  logic [WIDTH-1:0] p0_q, g0_q;
  pg_t              row_s [0:NUM_ROWS][0:WIDTH-1];
  logic [WIDTH-1:0] c_s;
  logic [WIDTH-1:0] d_s;
  logic             cout_s;

  logic             out_valid_q, bout_q, zero_q, neg_q, ovf_q;
  logic [WIDTH-1:0] d_q;

  assign adv_s    = ~out_valid_q | out_ready;
  assign in_ready = adv_s;

  // Index 0 of each prefix row is bit -1 (carry-in); index j holds bit j-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      p0_q <= '0;
      g0_q <= '0;
      for (int r = 0; r <= NUM_ROWS; r++) begin
        a_q[r]  <= '0;
        nb_q[r] <= '0;
      end
    end else if (adv_s) begin
      v_q[0]  <= in_valid;
      a_q[0]  <= a;
      nb_q[0] <= ~b;
      p0_q    <= {a[WIDTH-2:0] | ~b[WIDTH-2:0], 1'b0};
      g0_q    <= {a[WIDTH-2:0] & ~b[WIDTH-2:0], ~bin};
      for (int r = 1; r <= NUM_ROWS; r++) begin
        v_q[r]  <= v_q[r-1];
        a_q[r]  <= a_q[r-1];
        nb_q[r] <= nb_q[r-1];
      end
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_row0
    assign row_s[0][j] = '{p: p0_q[j], g: g0_q[j]};
  end

  for (genvar r = 1; r <= NUM_ROWS; r++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      localparam int SPAN = 1 << (r - 1);
      pg_t right_s;
      if (j >= SPAN) begin : g_blk
        assign right_s = row_s[r-1][j-SPAN];
      end else begin : g_pass
        assign right_s = PG_IDENT;
      end
      pg_black_en u_cell (
        .clk   (clk),
        .reset (reset),
        .en_i  (adv_s),
        .l_i   (row_s[r-1][j]),
        .r_i   (right_s),
        .o_o   (row_s[r][j])
      );
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_carry
    assign c_s[j] = row_s[NUM_ROWS][j].g;
  end

  // Final sum, plus carry out of the MSB for borrow and overflow.
  always_comb begin
    d_s    = a_q[NUM_ROWS] ^ nb_q[NUM_ROWS] ^ c_s;
    cout_s = (a_q[NUM_ROWS][WIDTH-1] & nb_q[NUM_ROWS][WIDTH-1]) |
             ((a_q[NUM_ROWS][WIDTH-1] | nb_q[NUM_ROWS][WIDTH-1]) & c_s[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv_s) begin
      out_valid_q <= v_q[NUM_ROWS];
      d_q         <= d_s;
      bout_q      <= ~cout_s;
      zero_q      <= (d_s == 32'd0);
      neg_q       <= d_s[WIDTH-1];
      ovf_q       <= c_s[WIDTH-1] ^ cout_s;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Self-checking bench for prefix_sub_pipe: directed table, stall stream, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_prefix_sub_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        bout, zero, neg, ovf;

  prefix_sub_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout, zero, neg, ovf;
  } vec_t;

  vec_t        vecs [7];
  int          total = 0;
  int          bad = 0;
  logic [35:0] exp_q [$];
  logic [35:0] held;
  logic [35:0] last_out;
  bit          hold_chk = 1'b0;
  bit          popped;
  bit          accepted;
  int          ncyc = 0;
  int          pop_cyc = 0;
  int          npop = 0;

  // Reference: plain integer arithmetic; result packed as {d, bout, zero, neg, ovf}.
  function automatic logic [35:0] model(input logic [31:0] ai, input logic [31:0] bi, input logic bn);
    logic [31:0] dd;
    logic        bo, o;
    longint      sd;
    dd = ai - bi - {31'd0, bn};
    bo = ({1'b0, ai} < ({1'b0, bi} + {32'd0, bn}));
    sd = longint'($signed(ai)) - longint'($signed(bi)) - (bn ? 64'sd1 : 64'sd0);
    o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {dd, bo, (dd == 32'd0), dd[31], o};
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ai, input logic [31:0] bi,
                       input logic bn, input logic ordy);
    @(negedge clk);
    in_valid = iv; a = ai; b = bi; bin = bn; out_ready = ordy;
    #1;
    if (hold_chk)
      chk("hold", {d, bout, zero, neg, ovf}, held);
    hold_chk = out_valid && !out_ready;
    held = {d, bout, zero, neg, ovf};
    chk("in_ready", {35'd0, in_ready}, {35'd0, (!out_valid || out_ready)});
    if (out_valid && out_ready) begin
      popped = 1'b1;
      pop_cyc = ncyc;
      npop++;
      last_out = {d, bout, zero, neg, ovf};
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious: got result %h expected no result (cycle %0d)", last_out, ncyc);
      end else begin
        chk("scoreboard", last_out, exp_q.pop_front());
      end
    end
    accepted = in_valid && in_ready;
    if (accepted)
      exp_q.push_back(model(ai, bi, bn));
    ncyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("drain_empty", 36'(exp_q.size()), 36'd0);
  endtask

  task automatic run_vec(input int i);
    int acc;
    drain();
    popped = 1'b0;
    cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1);
    acc = ncyc - 1;
    chk("vec_accept", {35'd0, accepted}, 36'd1);
    for (int k = 0; k < 15 && !popped; k++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    if (!popped) begin
      total++; bad++;
      $display("FAIL latency_timeout: got no result expected one after 7 cycles (vec %0d)", i);
    end else begin
      chk($sformatf("latency_vec%0d", i), 36'(pop_cyc - acc), 36'd7);
      chk($sformatf("table_vec%0d", i), last_out,
          {vecs[i].d, vecs[i].bout, vecs[i].zero, vecs[i].neg, vecs[i].ovf});
    end
  endtask

  initial begin
    logic [31:0] sa [20];
    logic [31:0] sb [20];
    logic        sbin [20];
    int          idx, stall, start;
    logic        ordy;

    vecs[0] = '{32'd10,         32'd3,          1'b0, 32'd7,          1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'd5,          32'd5,          1'b0, 32'd0,          1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'd5,          32'd4,          1'b1, 32'd0,          1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_out", {out_valid, d, bout, zero, neg}, 36'd0);
    chk("reset_ovf_ready", {34'd0, ovf, in_ready}, 36'd1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_vec(i);

    // Back-to-back stream of 20 with a 3-cycle consumer stall at result 4.
    for (int i = 0; i < 20; i++) begin
      sa[i] = $urandom; sb[i] = $urandom; sbin[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; stall = 0; start = npop;
    for (int c = 0; c < 200 && (idx < 20 || exp_q.size() > 0); c++) begin
      ordy = !((npop - start == 4) && stall < 3);
      if (!ordy) stall++;
      if (idx < 20) cycle(1'b1, sa[idx], sb[idx], sbin[idx], ordy);
      else          cycle(1'b0, 32'd0, 32'd0, 1'b0, ordy);
      if (accepted) idx++;
    end
    chk("stream_count", 36'(npop - start), 36'd20);
    chk("stream_stall", 36'(stall), 36'd3);

    // Reset with four operand sets in flight.
    drain();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {out_valid, d, bout, zero, neg}, 36'd0);
    exp_q.delete();
    hold_chk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    run_vec(0);

    // Randomized traffic with random handshakes and edge-biased operands.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      cycle(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
